// File: rtl/dip_pkg.sv
// dip_pkg: shared state encoding, default group width and switch-off reset level for the DIP debouncer
package dip_pkg;
  localparam logic DEB_IDLE = 1'b0;
  localparam logic DEB_COUNT = 1'b1;
  localparam int DIP_GROUP_W = 8;
  localparam logic DIP_OFF_BIT = 1'b1;
  typedef enum logic {
    S_IDLE = DEB_IDLE,
    S_COUNT = DEB_COUNT
  } deb_state_t;
endpackage

// File: rtl/dip_debounce_group.sv
// dip_debounce_group: two-flop synchronizer plus whole-word debounce filter for one switch group
module dip_debounce_group
  import dip_pkg::*;
#(
  parameter int GROUP_W = DIP_GROUP_W,
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [GROUP_W-1:0] raw,
  output logic [GROUP_W-1:0] stable,
  output logic               change,
  output logic               commit
);
  localparam logic [GROUP_W-1:0] OFF = {GROUP_W{DIP_OFF_BIT}};
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  logic [GROUP_W-1:0] sync1, sync2, cand, cand_nxt, stable_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  deb_state_t state, state_nxt;
  // Filter decision: a new word must be seen unchanged for DEBOUNCE_CYCLES samples before it is accepted
  always_comb begin
    state_nxt = state;
    cand_nxt = cand;
    cnt_nxt = cnt;
    stable_nxt = stable;
    commit = 1'b0;
    if (state == S_IDLE) begin
      if (sync2 != stable) begin
        cand_nxt = sync2;
        cnt_nxt = CNT_W'(1);
        state_nxt = S_COUNT;
      end
    end else if (sync2 == cand) begin
      if (cnt == LAST) begin
        stable_nxt = cand;
        cnt_nxt = '0;
        commit = 1'b1;
        state_nxt = S_IDLE;
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
    end else if (sync2 == stable) begin
      cnt_nxt = '0;
      state_nxt = S_IDLE;
    end else begin
      cand_nxt = sync2;
      cnt_nxt = CNT_W'(1);
    end
  end
  // Synchronizer, filter state and registered one-cycle change pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= OFF;
      sync2 <= OFF;
      cand <= OFF;
      stable <= OFF;
      cnt <= '0;
      state <= S_IDLE;
      change <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      cand <= cand_nxt;
      stable <= stable_nxt;
      cnt <= cnt_nxt;
      state <= state_nxt;
      change <= commit;
    end
  end
endmodule

// File: rtl/dip_debounce.sv
// dip_debounce: per-group DIP switch debouncer with change mask; DIP_IRQ_EN adds a sticky change interrupt
module dip_debounce
  import dip_pkg::*;
#(
  parameter int NUM_GROUPS = 8,
  parameter int GROUP_W = DIP_GROUP_W,
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int CNT_W = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_GROUPS*GROUP_W-1:0] dip_raw,
  output logic [NUM_GROUPS*GROUP_W-1:0] dip_stable,
  output logic [NUM_GROUPS-1:0]         change_mask,
  output logic                          change_any,
  output logic                          irq,
  input  logic                          irq_ack
);
  logic [NUM_GROUPS-1:0] commit;
  for (genvar g = 0; g < NUM_GROUPS; g++) begin : g_grp
    dip_debounce_group #(
      .GROUP_W(GROUP_W),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W(CNT_W)
    ) u_grp (
      .clk(clk),
      .reset(reset),
      .raw(dip_raw[g*GROUP_W +: GROUP_W]),
      .stable(dip_stable[g*GROUP_W +: GROUP_W]),
      .change(change_mask[g]),
      .commit(commit[g])
    );
  end
  // Registered from the same commit terms as change_mask so both rise in the same cycle
  always_ff @(posedge clk) begin
    change_any <= reset ? 1'b0 : |commit;
  end
`ifdef DIP_IRQ_EN
  // Sticky interrupt: a new change wins over a coincident acknowledge
  always_ff @(posedge clk) begin
    irq <= reset ? 1'b0 : change_any | (irq & ~irq_ack);
  end
`else
  logic unused_irq_ack;
  assign unused_irq_ack = irq_ack;
  assign irq = 1'b0;
`endif
endmodule

// File: tb/tb_dip_debounce.sv
// tb_dip_debounce: directed plus randomized check of dip_debounce against a run-length reference model
module tb_dip_debounce;
  localparam int NG = 8;
  localparam int DEB = 4;
`ifdef DIP_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic irq_ack = 1'b0;
  logic [NG*8-1:0] dip_raw = '0;
  logic [NG*8-1:0] dip_stable;
  logic [NG-1:0] change_mask;
  logic change_any, irq;
  int total = 0;
  int bad = 0;
  int pulses = 0;
  logic [NG-1:0] seen_mask = '0;
  logic [NG*8-1:0] p1 = '1, p2 = '1, m_stable = '1;
  logic [NG-1:0] m_mask = '0;
  logic m_any = 1'b0, m_irq = 1'b0;
  int run_len [NG];
  logic [7:0] last_val [NG];
  logic [7:0] vals [5] = '{8'hFF, 8'hFE, 8'h00, 8'h0F, 8'hA5};

  dip_debounce #(.NUM_GROUPS(NG), .GROUP_W(8), .DEBOUNCE_CYCLES(DEB), .CNT_W(16)) dut (
    .clk(clk),
    .reset(reset),
    .dip_raw(dip_raw),
    .dip_stable(dip_stable),
    .change_mask(change_mask),
    .change_any(change_any),
    .irq(irq),
    .irq_ack(irq_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: advance the model with the inputs sampled at this edge, then compare
  task automatic step();
    logic [NG*8-1:0] obs;
    logic [7:0] v;
    @(posedge clk);
    if (reset) begin
      p1 = '1;
      p2 = '1;
      m_stable = '1;
      m_mask = '0;
      m_any = 1'b0;
      m_irq = 1'b0;
      for (int g = 0; g < NG; g++) begin
        run_len[g] = 0;
        last_val[g] = 8'hFF;
      end
    end else begin
      obs = p2;
      p2 = p1;
      p1 = dip_raw;
      m_irq = IRQ_EN & (m_any | (m_irq & ~irq_ack));
      m_mask = '0;
      for (int g = 0; g < NG; g++) begin
        v = obs[g*8 +: 8];
        run_len[g] = (v == last_val[g]) ? run_len[g] + 1 : 1;
        last_val[g] = v;
        if (v != m_stable[g*8 +: 8] && run_len[g] == DEB) begin
          m_stable[g*8 +: 8] = v;
          m_mask[g] = 1'b1;
        end
      end
      m_any = |m_mask;
    end
    #1;
    check("stable", dip_stable, m_stable);
    check("mask", 64'(change_mask), 64'(m_mask));
    check("any", 64'(change_any), 64'(m_any));
    check("irq", 64'(irq), 64'(m_irq));
    seen_mask |= change_mask;
    if (change_mask != '0) pulses++;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    for (int g = 0; g < NG; g++) begin
      run_len[g] = 0;
      last_val[g] = 8'hFF;
    end
    steps(2);
    check("rst_stable", dip_stable, 64'hFFFF_FFFF_FFFF_FFFF);
    check("rst_mask", 64'(change_mask), 64'h0);
    check("rst_irq", 64'(irq), 64'h0);
    reset = 1'b0;
    dip_raw = '1;
    steps(4);
    dip_raw[7:0] = 8'hFE;
    steps(5);
    check("clean_pre", 64'(dip_stable[7:0]), 64'hFF);
    step();
    check("clean_val", 64'(dip_stable[7:0]), 64'hFE);
    check("clean_mask", 64'(change_mask), 64'h01);
    check("clean_any", 64'(change_any), 64'h1);
    step();
    check("clean_mask_end", 64'(change_mask), 64'h00);
    check("irq_set", 64'(irq), 64'(IRQ_EN));
    steps(10);
    check("irq_hold", 64'(irq), 64'(IRQ_EN));
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    check("irq_ack", 64'(irq), 64'h0);
    dip_raw = '1;
    steps(10);
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    dip_raw[7:0] = 8'hFE;
    steps(6);
    check("coinc_any", 64'(change_any), 64'h1);
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    check("irq_coinc", 64'(irq), 64'(IRQ_EN));
    dip_raw = '1;
    steps(10);
    seen_mask = '0;
    dip_raw[31:24] = 8'h00;
    steps(3);
    dip_raw[31:24] = 8'hFF;
    steps(8);
    check("glitch_mask", 64'(seen_mask), 64'h0);
    check("glitch_val", 64'(dip_stable[31:24]), 64'hFF);
    pulses = 0;
    dip_raw[15:8] = 8'hF0;
    steps(2);
    dip_raw[15:8] = 8'h0F;
    steps(5);
    check("restart_pre", 64'(dip_stable[15:8]), 64'hFF);
    step();
    check("restart_val", 64'(dip_stable[15:8]), 64'h0F);
    check("restart_mask", 64'(change_mask), 64'h02);
    steps(4);
    check("restart_pulses", 64'(pulses), 64'h1);
    dip_raw = '1;
    steps(10);
    dip_raw[23:16] = 8'h00;
    dip_raw[47:40] = 8'h3C;
    steps(6);
    check("simul_mask", 64'(change_mask), 64'h24);
    dip_raw = '1;
    steps(10);
    dip_raw[23:16] = 8'h55;
    dip_raw[47:40] = 8'h55;
    steps(3);
    reset = 1'b1;
    dip_raw = '1;
    step();
    reset = 1'b0;
    pulses = 0;
    steps(10);
    check("midrst_pulses", 64'(pulses), 64'h0);
    check("midrst_stable", dip_stable, 64'hFFFF_FFFF_FFFF_FFFF);
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 5) == 0)
        dip_raw[$urandom_range(0, NG-1)*8 +: 8] = vals[$urandom_range(0, 4)];
      irq_ack = ($urandom_range(0, 3) == 0);
      reset = ($urandom_range(0, 299) == 0);
      step();
    end
    reset = 1'b0;
    irq_ack = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dip_debounce.md
Name: dip_debounce

Overview:
- Conditions raw FPGA DIP-switch pins before they reach the switch peripheral: two-flop synchronizer, then per-group debounce filter.
- Sits directly upstream of the switch peripheral; its dip_stable groups drive dip_switch0..7 of that peripheral.
- Emits a one-cycle per-group change mask, plus an optional sticky interrupt, for the bridge/CP0 path.

Parameters:
- NUM_GROUPS, 8, number of 8-bit switch groups.
- GROUP_W, 8, bits per group.
- DEBOUNCE_CYCLES, 20000, consecutive stable cycles required before accepting a new group value; legal range 2..65535.
- CNT_W, 16, debounce counter width; must hold DEBOUNCE_CYCLES-1.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- dip_raw  input  NUM_GROUPS*GROUP_W  asynchronous switch pins, active-low; group g = bits [g*8+7:g*8].
- dip_stable  output  NUM_GROUPS*GROUP_W  debounced pin levels, same polarity as dip_raw.
- change_mask  output  NUM_GROUPS  bit g high for one cycle when group g's stable value updates.
- change_any  output  1  OR of change_mask, registered in the same cycle as change_mask.
- irq  output  1  sticky change interrupt; constant 0 unless DIP_IRQ_EN is defined.
- irq_ack  input  1  clears irq; ignored unless DIP_IRQ_EN is defined.

Behaviour:
- Clock and reset: clk only. Reset is synchronous, active-high.
- Reset values:
  - sync1, sync2, candidate and dip_stable all ones (switches off).
  - Counters 0, all groups in IDLE.
  - change_mask, change_any and irq all 0.
  - Reset asserted mid-count discards the count; the pending value is not committed.
- Synchronizer:
  - sync1 <= dip_raw, sync2 <= sync1, every cycle.
  - The filter sees only sync2.
- Per-group FSM, states IDLE and COUNT, whole group handled as one 8-bit word:
  - IDLE, sync2 == stable: stay in IDLE.
  - IDLE, sync2 != stable: candidate <= sync2, cnt <= 1, go to COUNT.
  - COUNT, sync2 == candidate, cnt == DEBOUNCE_CYCLES-1: stable <= candidate, cnt <= 0, change_mask[g] <= 1, go to IDLE.
  - COUNT, sync2 == candidate, otherwise: cnt <= cnt+1.
  - COUNT, sync2 == stable (glitch returned): cnt <= 0, go to IDLE, no pulse.
  - COUNT, sync2 differs from both candidate and stable: candidate <= sync2, cnt <= 1, stay in COUNT.
- change_mask[g] is 0 in every cycle other than the commit cycle.
- Latency: call edge 1 the first edge that samples a new raw value held steady. dip_stable and change_mask update at edge DEBOUNCE_CYCLES+2.
- Groups are independent. Simultaneous commits in several groups set several mask bits in the same cycle.
- No wrap-around: cnt never exceeds DEBOUNCE_CYCLES-1.

Optional Feature:
- Macro: DIP_IRQ_EN.
- Defined:
  - irq <= 1 in any cycle where change_any is 1; irq <= 0 when irq_ack is high and no new change occurs.
  - A set in the same cycle as irq_ack wins: irq stays 1.
  - irq holds across cycles until acknowledged.
- Undefined: irq tied to 0, irq_ack unused, no interrupt flop synthesized.

Decomposition:
- Package dip_pkg holds:
  - state encoding localparams DEB_IDLE = 1'b0, DEB_COUNT = 1'b1;
  - GROUP_W default;
  - the reset constant (all ones).
- Sub-module dip_debounce_group: one group's synchronizer, FSM, counter and stable register, plus its change pulse. Instantiated NUM_GROUPS times via generate.
- The top level holds only the generate loop, the change_any OR and the optional irq flop.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset: assert reset for 2 cycles with dip_raw=0 -> dip_stable=64'hFFFF_FFFF_FFFF_FFFF, change_mask=0, irq=0.
- Clean change: group0 raw goes from 8'hFF to 8'hFE before edge 1 and is held -> dip_stable[7:0]=8'hFE after edge 6; change_mask=8'h01 for exactly one cycle; change_any=1 in that same cycle.
- Glitch rejection: group3 raw goes 8'hFF->8'h00 for 3 cycles, then back to 8'hFF -> dip_stable[31:24] stays 8'hFF, no change_mask pulse.
- Restart on new value: group1 raw goes 8'hFF->8'hF0 for 2 cycles, then 8'h0F and held -> only 8'h0F is committed, 4 cycles after sync2 first shows 8'h0F; no intermediate commit.
- Simultaneous groups plus mid-count reset:
  - groups 2 and 5 change on the same edge -> change_mask=8'h24 in one cycle.
  - repeat, with reset asserted at edge 4 -> stable stays all ones, no pulse.
- DIP_IRQ_EN:
  - a commit sets irq; irq holds for 10 cycles; irq_ack drops it the next cycle.
  - irq_ack coincident with a new change_any -> irq remains 1.
